// File: rtl/fft8_reorder_if.sv
// Bundle of the reorder stage's control, RAM read and output stream signals.
// master is the reorder block's view; slave is the FFT/RAM/consumer side.
interface fft8_reorder_if #(
  parameter int unsigned N_LOG2 = 3,
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 16
);
  logic              start;
  logic              busy;
  logic              done;
  logic              ram_rd;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_re_i;
  logic [DW-1:0]     ram_im_i;
  logic              m_valid;
  logic              m_ready;
  logic [DW-1:0]     m_re;
  logic [DW-1:0]     m_im;
  logic [N_LOG2-1:0] m_index;
  logic              m_last;

  modport master (
    input  start, ram_re_i, ram_im_i, m_ready,
    output busy, done, ram_rd, ram_addr, m_valid, m_re, m_im, m_index, m_last
  );

  modport slave (
    output start, ram_re_i, ram_im_i, m_ready,
    input  busy, done, ram_rd, ram_addr, m_valid, m_re, m_im, m_index, m_last
  );
endinterface

// File: rtl/fft8_reorder.sv
// Reads FFT results in bit-reversed address order and streams them out in natural
// order over valid/ready; a 2-entry skid FIFO covers the 1-cycle RAM read latency.
module fft8_reorder #(
  parameter int unsigned N_LOG2 = 3,
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  fft8_reorder_if.master bus
);
  localparam int unsigned N  = 1 << N_LOG2;
  localparam int unsigned CW = N_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              inflight_q;
  logic [N_LOG2-1:0] inflight_idx_q;
  logic [CW-1:0]     rd_cnt_q;

  logic [DW-1:0]     fifo_re_q  [2];
  logic [DW-1:0]     fifo_im_q  [2];
  logic [N_LOG2-1:0] fifo_idx_q [2];
  logic [1:0]        fifo_last_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        credit_used;
  logic [N_LOG2-1:0] rd_idx;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] k);
    logic [N_LOG2-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N_LOG2; i++) r[i] = k[N_LOG2-1-i];
    return r;
  endfunction

  // Read strobe stays combinational so a pop in this cycle frees a slot immediately.
  always_comb begin
    pop         = (occ_q != 2'd0) && bus.m_ready;
    push        = inflight_q;
    credit_used = {1'b0, occ_q} + {2'b00, inflight_q};
    rd_idx      = rd_cnt_q[N_LOG2-1:0];
    issue       = (state_q == RUN) && (rd_cnt_q < CW'(N)) &&
                  (credit_used < (3'd2 + {2'b00, pop}));
  end

  assign bus.ram_rd   = issue;
  assign bus.ram_addr = issue ? AW'(bitrev(rd_idx)) : '0;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.m_valid  = (occ_q != 2'd0);
  assign bus.m_re     = fifo_re_q[rd_ptr_q];
  assign bus.m_im     = fifo_im_q[rd_ptr_q];
  assign bus.m_index  = fifo_idx_q[rd_ptr_q];
  assign bus.m_last   = fifo_last_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      rd_cnt_q       <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      occ_q          <= '0;
      fifo_last_q    <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_re_q[i]  <= '0;
        fifo_im_q[i]  <= '0;
        fifo_idx_q[i] <= '0;
      end
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_idx_q <= rd_idx;
        rd_cnt_q       <= rd_cnt_q + CW'(1);
      end

      if (push) begin
        fifo_re_q[wr_ptr_q]   <= bus.ram_re_i;
        fifo_im_q[wr_ptr_q]   <= bus.ram_im_i;
        fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
        fifo_last_q[wr_ptr_q] <= (inflight_idx_q == N_LOG2'(N - 1));
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;

      if (push && !pop)      occ_q <= occ_q + 2'd1;
      else if (pop && !push) occ_q <= occ_q - 2'd1;

      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            rd_cnt_q   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
          end
        end
        RUN: begin
          if (rd_cnt_q == CW'(N)) state_q <= DRAIN;
          if (pop && fifo_last_q[rd_ptr_q]) begin
            done_q  <= 1'b1;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // done is held for exactly the cycle after the last beat leaves.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (pop && fifo_last_q[rd_ptr_q]) begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft8_reorder.sv
// Randomized and directed bench for fft8_reorder against a natural-order model.
module tb_fft8_reorder;
  localparam int unsigned N_LOG2 = 3;
  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 16;
  localparam int unsigned N      = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft8_reorder_if #(.N_LOG2(N_LOG2), .DW(DW), .AW(AW)) bus ();
  fft8_reorder #(.N_LOG2(N_LOG2), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] re_mem [N];
  logic [DW-1:0] im_mem [N];
  logic [DW-1:0] exp_re [N];
  logic [DW-1:0] exp_im [N];

  int n_checks = 0;
  int n_pass   = 0;

  // Synchronous-read RAM pair: data one cycle after the strobe.
  always @(posedge clk) begin
    if (bus.ram_rd) begin
      bus.ram_re_i <= re_mem[bus.ram_addr[N_LOG2-1:0]];
      bus.ram_im_i <= im_mem[bus.ram_addr[N_LOG2-1:0]];
    end
  end

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int unsigned rev3(input int unsigned k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  function automatic void build_model();
    for (int k = 0; k < N; k++) begin
      exp_re[k] = re_mem[rev3(k)];
      exp_im[k] = im_mem[rev3(k)];
    end
  endfunction

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      2:       return cyc > 10;
      default: return $urandom_range(0, 3) != 0;
    endcase
  endfunction

  // mode 0: ready high, 1: toggling, 2: 10-cycle stall, 3: random ready.
  task automatic run_frame(input int mode, input int restart_at, input bit start_in_done,
                           input string name);
    int acc = 0, first_v = -1, last_pop = -1, done_cyc = -1, done_cnt = 0;
    int busy_first = -1, busy_last = -1, rd_stall = 0, issued = 0, popped = 0, max_out = 0;
    bit held = 1'b0;
    logic [DW-1:0] h_re, h_im;
    logic [N_LOG2-1:0] h_idx;
    logic h_last;
    build_model();
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.m_ready = ready_for(mode, 0);
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        bus.start   = (cyc == restart_at) || (start_in_done && bus.done);
        bus.m_ready = ready_for(mode, cyc);
      end
      @(negedge clk);
      if (bus.ram_rd) begin
        check({name, " addr"}, 72'(bus.ram_addr), 72'(rev3(issued % N)));
        issued++;
        if (mode == 2 && cyc >= 1 && cyc <= 10) rd_stall++;
      end
      if (held)
        check({name, " hold"}, 72'({bus.m_valid, bus.m_re, bus.m_im, bus.m_index, bus.m_last}),
              72'({1'b1, h_re, h_im, h_idx, h_last}));
      if (mode == 2 && cyc == 10)
        check({name, " stall head"}, 72'({bus.m_valid, bus.m_index, bus.m_re}),
              72'({1'b1, 3'd0, exp_re[0]}));
      if (bus.m_valid && first_v < 0) first_v = cyc;
      if (bus.m_valid && bus.m_ready) begin
        if (acc < N) begin
          check({name, " re"}, 72'(bus.m_re), 72'(exp_re[acc]));
          check({name, " im"}, 72'(bus.m_im), 72'(exp_im[acc]));
          check({name, " index"}, 72'(bus.m_index), 72'(acc));
          check({name, " last"}, 72'(bus.m_last), 72'(acc == N - 1));
        end else begin
          check({name, " extra beat"}, 72'(1), 72'(0));
        end
        acc++;
        popped++;
        last_pop = cyc;
      end
      held = bus.m_valid && !bus.m_ready;
      h_re = bus.m_re; h_im = bus.m_im; h_idx = bus.m_index; h_last = bus.m_last;
      if (issued - popped > max_out) max_out = issued - popped;
      if (bus.busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    bus.start = 1'b0;
    check({name, " beats"}, 72'(acc), 72'(N));
    check({name, " done count"}, 72'(done_cnt), 72'(1));
    check({name, " fifo credit"}, 72'(max_out <= 2), 72'(1));
    if (mode == 0) begin
      check({name, " first valid cyc"}, 72'(first_v), 72'(3));
      check({name, " last pop cyc"}, 72'(last_pop), 72'(10));
      check({name, " done cyc"}, 72'(done_cyc), 72'(11));
      check({name, " busy first"}, 72'(busy_first), 72'(1));
      check({name, " busy last"}, 72'(busy_last), 72'(11));
    end
    if (mode == 2) check({name, " reads in stall"}, 72'(rd_stall <= 2), 72'(1));
  endtask

  task automatic reset_midframe();
    int dones = 0;
    build_model();
    @(posedge clk); #1;
    bus.start   = 1'b1;
    bus.m_ready = 1'b1;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
        bus.start = 1'b0;
        rst_n     = !(cyc == 6 || cyc == 7);
      end
      @(negedge clk);
      if (cyc == 7)
        check("mid reset outputs",
              72'({bus.busy, bus.done, bus.ram_rd, bus.ram_addr, bus.m_valid,
                   bus.m_index, bus.m_last}), 72'(0));
      if (cyc == 7) check("mid reset data", 72'({bus.m_re, bus.m_im}), 72'(0));
      if (cyc >= 7 && bus.done) dones++;
    end
    rst_n = 1'b1;
    check("no done after reset", 72'(dones), 72'(0));
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.m_ready = 1'b0;
    rst_n       = 1'b0;
    for (int a = 0; a < N; a++) begin
      re_mem[a] = DW'(a);
      im_mem[a] = DW'(100 + a);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs",
          72'({bus.busy, bus.done, bus.ram_rd, bus.ram_addr, bus.m_valid,
               bus.m_index, bus.m_last}), 72'(0));
    check("reset data", 72'({bus.m_re, bus.m_im}), 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_frame(0, -1, 1'b0, "seq");
    run_frame(1, -1, 1'b0, "toggle");
    run_frame(2, -1, 1'b0, "stall");
    run_frame(0, 5, 1'b1, "restart");
    run_frame(0, -1, 1'b0, "next");
    reset_midframe();
    run_frame(0, -1, 1'b0, "after reset");

    for (int a = 0; a < N; a++) begin
      re_mem[a] = 32'h8000_0000;
      im_mem[a] = 32'hFFFF_FFFF;
    end
    run_frame(0, -1, 1'b0, "full range");

    for (int f = 0; f < 4; f++) begin
      for (int a = 0; a < N; a++) begin
        re_mem[a] = $urandom;
        im_mem[a] = $urandom;
      end
      run_frame(3, -1, 1'b0, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
